// File: rtl/ysyx_22040125_bru.sv
// ysyx_22040125_bru -- branch-resolution unit for the EXU stage.
//
// Resolves conditional branches (beq/bne/blt/bge/bltu/bgeu) and unconditional
// jumps, compares the outcome with the IFU prediction, and holds the result in
// a one-entry output register with a valid/ready handshake. A misprediction
// raises out_redirect and forces pc_sel_out to BR_PC_SEL.
//
// Ports:
//   clk, rst            clock, synchronous active-high reset
//   in_valid/in_ready   upstream handshake (in_ready drops during flush)
//   b_check[5:0]        one-hot condition select: beq,bne,blt,bge,bltu,bgeu
//   jump                unconditional jump
//   rs1_data, rs2_data  compare operands
//   pc, target          branch PC and computed taken target
//   pred_taken/target   IFU prediction
//   pc_sel              default PC select from decode
//   flush               drops the held entry, blocks acceptance this cycle
//   out_valid/out_ready downstream handshake
//   out_taken, out_redirect, out_next_pc, pc_sel_out   registered result
//   perf_br_cnt, perf_mis_cnt                          performance counters
//
// Optional feature: define BRU_PERF_CNT_EN to build saturating handshake and
// mispredict counters; otherwise both counter ports are tied to zero.

module ysyx_22040125_bru #(
    parameter int         XLEN      = 64,
    parameter int         CNT_W     = 32,
    parameter logic [2:0] BR_PC_SEL = 3'b010
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [5:0]       b_check,
    input  logic             jump,
    input  logic [XLEN-1:0]  rs1_data,
    input  logic [XLEN-1:0]  rs2_data,
    input  logic [XLEN-1:0]  pc,
    input  logic [XLEN-1:0]  target,
    input  logic             pred_taken,
    input  logic [XLEN-1:0]  pred_target,
    input  logic [2:0]       pc_sel,
    input  logic             flush,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             out_taken,
    output logic             out_redirect,
    output logic [XLEN-1:0]  out_next_pc,
    output logic [2:0]       pc_sel_out,
    output logic [CNT_W-1:0] perf_br_cnt,
    output logic [CNT_W-1:0] perf_mis_cnt
);

    // Saturating increment for the performance counters.
    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + {{(CNT_W-1){1'b0}}, 1'b1};
    endfunction

    logic            accept;
    logic [XLEN:0]   sum_p0;
    logic            eq_p0;
    logic            ltu_p0;
    logic            lt_p0;
    logic            cond_p0;
    logic            taken_p0;
    logic            redirect_p0;
    logic [XLEN-1:0] next_pc_p0;

    logic            vld_p1;
    logic            taken_p1;
    logic            redirect_p1;
    logic [XLEN-1:0] next_pc_p1;
    logic [2:0]      pc_sel_p1;

    assign in_ready = ~flush & (~vld_p1 | out_ready);
    assign accept   = in_valid & in_ready;

    // ---- stage p0: combinational resolution of the offered branch ----
    always_comb begin
        // rs1 - rs2 computed as rs1 + ~rs2 + 1 with a carry-out bit;
        // no carry means rs1 < rs2 unsigned.
        sum_p0 = {1'b0, rs1_data} + {1'b0, ~rs2_data} + {{XLEN{1'b0}}, 1'b1};
        eq_p0  = (rs1_data == rs2_data);
        ltu_p0 = ~sum_p0[XLEN];
        // Signed less-than: negative vs non-negative decides directly,
        // same signs fall back to the sign of the difference.
        lt_p0  = (rs1_data[XLEN-1] & ~rs2_data[XLEN-1])
               | (~(rs1_data[XLEN-1] ^ rs2_data[XLEN-1]) & sum_p0[XLEN-1]);
        // Multiple select bits simply OR together.
        cond_p0 = (b_check[5] &  eq_p0)
                | (b_check[4] & ~eq_p0)
                | (b_check[3] &  lt_p0)
                | (b_check[2] & ~lt_p0)
                | (b_check[1] &  ltu_p0)
                | (b_check[0] & ~ltu_p0);
        taken_p0 = jump | cond_p0;
        next_pc_p0 = taken_p0 ? target : pc + {{(XLEN-3){1'b0}}, 3'b100};
        // A not-taken branch predicted not-taken ignores pred_target.
        redirect_p0 = (taken_p0 != pred_taken)
                    | (taken_p0 & (target != pred_target));
    end

    // ---- stage p1: one-entry output register ----
    always_ff @(posedge clk) begin
        if (rst) begin
            vld_p1      <= 1'b0;
            taken_p1    <= 1'b0;
            redirect_p1 <= 1'b0;
            next_pc_p1  <= '0;
            pc_sel_p1   <= 3'b000;
        end else if (flush) begin
            vld_p1 <= 1'b0;
        end else if (accept) begin
            vld_p1      <= 1'b1;
            taken_p1    <= taken_p0;
            redirect_p1 <= redirect_p0;
            next_pc_p1  <= next_pc_p0;
            pc_sel_p1   <= pc_sel;
        end else if (vld_p1 & out_ready) begin
            vld_p1 <= 1'b0;
        end
    end

    assign out_valid    = vld_p1;
    assign out_taken    = taken_p1;
    assign out_redirect = redirect_p1;
    assign out_next_pc  = next_pc_p1;
    assign pc_sel_out   = redirect_p1 ? BR_PC_SEL : pc_sel_p1;

`ifdef BRU_PERF_CNT_EN
    logic             hs_p1;
    logic [CNT_W-1:0] br_cnt_q;
    logic [CNT_W-1:0] mis_cnt_q;

    // A flushed entry is dropped, so it never counts as retired.
    assign hs_p1 = vld_p1 & out_ready & ~flush;

    always_ff @(posedge clk) begin
        if (rst) begin
            br_cnt_q  <= '0;
            mis_cnt_q <= '0;
        end else if (hs_p1) begin
            br_cnt_q <= sat_inc(br_cnt_q);
            if (redirect_p1) begin
                mis_cnt_q <= sat_inc(mis_cnt_q);
            end
        end
    end

    assign perf_br_cnt  = br_cnt_q;
    assign perf_mis_cnt = mis_cnt_q;
`else
    assign perf_br_cnt  = '0;
    assign perf_mis_cnt = '0;
`endif

endmodule

// File: tb/tb_ysyx_22040125_bru.sv
// Testbench for ysyx_22040125_bru: directed steps plus a short random burst,
// results predicted by an independent model and queued in a scoreboard.
module tb_ysyx_22040125_bru;

    localparam int XLEN  = 64;
    localparam int CNT_W = 4;

    logic             clk = 1'b0;
    logic             rst;
    logic             in_valid;
    logic             in_ready;
    logic [5:0]       b_check;
    logic             jump;
    logic [XLEN-1:0]  rs1_data, rs2_data, pc, target, pred_target;
    logic             pred_taken;
    logic [2:0]       pc_sel;
    logic             flush;
    logic             out_valid;
    logic             out_ready;
    logic             out_taken;
    logic             out_redirect;
    logic [XLEN-1:0]  out_next_pc;
    logic [2:0]       pc_sel_out;
    logic [CNT_W-1:0] perf_br_cnt;
    logic [CNT_W-1:0] perf_mis_cnt;

    ysyx_22040125_bru #(.XLEN(XLEN), .CNT_W(CNT_W), .BR_PC_SEL(3'b010)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .b_check(b_check), .jump(jump), .rs1_data(rs1_data), .rs2_data(rs2_data),
        .pc(pc), .target(target), .pred_taken(pred_taken), .pred_target(pred_target),
        .pc_sel(pc_sel), .flush(flush), .out_valid(out_valid), .out_ready(out_ready),
        .out_taken(out_taken), .out_redirect(out_redirect), .out_next_pc(out_next_pc),
        .pc_sel_out(pc_sel_out), .perf_br_cnt(perf_br_cnt), .perf_mis_cnt(perf_mis_cnt)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic            taken;
        logic            redirect;
        logic [XLEN-1:0] npc;
        logic [2:0]      psel;
    } exp_t;

    exp_t             sb[$];
    logic             mdl_valid = 1'b0;
    logic [CNT_W-1:0] mdl_br = '0;
    logic [CNT_W-1:0] mdl_mis = '0;
    int               n_checks = 0;
    int               n_fail = 0;

    task automatic chk(input string tag, input logic [XLEN-1:0] obs, input logic [XLEN-1:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [CNT_W-1:0] sat(input logic [CNT_W-1:0] v);
        return (v == {CNT_W{1'b1}}) ? v : v + 1;
    endfunction

    // Reference behaviour built from native signed/unsigned comparisons.
    function automatic exp_t model();
        exp_t e;
        logic eq, lt, ltu, cond;
        eq   = (rs1_data == rs2_data);
        lt   = ($signed(rs1_data) < $signed(rs2_data));
        ltu  = (rs1_data < rs2_data);
        cond = (b_check[5] && eq) || (b_check[4] && !eq) || (b_check[3] && lt)
            || (b_check[2] && !lt) || (b_check[1] && ltu) || (b_check[0] && !ltu);
        e.taken    = jump || cond;
        e.npc      = e.taken ? target : pc + 64'd4;
        e.redirect = (e.taken != pred_taken) || (e.taken && (target != pred_target));
        e.psel     = e.redirect ? 3'b010 : pc_sel;
        return e;
    endfunction

    // One clock: predict handshakes, advance the scoreboard, check outputs.
    task automatic tick();
        logic exp_ready, acc, hs;
        exp_t e;
        #1;
        exp_ready = !flush && (!mdl_valid || out_ready);
        if (!rst) chk("in_ready", in_ready, exp_ready);
        if (rst) begin
            mdl_valid = 1'b0;
            sb.delete();
            mdl_br  = '0;
            mdl_mis = '0;
        end else begin
            hs  = mdl_valid && out_ready && !flush;
            acc = in_valid && exp_ready;
            if (flush && mdl_valid && sb.size() > 0) void'(sb.pop_front());
            if (hs && sb.size() > 0) begin
                e = sb.pop_front();
                mdl_br = sat(mdl_br);
                if (e.redirect) mdl_mis = sat(mdl_mis);
            end
            if (acc) sb.push_back(model());
            mdl_valid = acc ? 1'b1 : ((flush || hs) ? 1'b0 : mdl_valid);
        end
        @(posedge clk);
        #1;
        chk("out_valid", out_valid, mdl_valid);
        if (mdl_valid) begin
            if (sb.size() == 0) begin
                chk("sb_empty", 1, 0);
            end else begin
                chk("out_taken", out_taken, sb[0].taken);
                chk("out_redirect", out_redirect, sb[0].redirect);
                chk("out_next_pc", out_next_pc, sb[0].npc);
                chk("pc_sel_out", pc_sel_out, sb[0].psel);
            end
        end
`ifdef BRU_PERF_CNT_EN
        chk("perf_br_cnt", perf_br_cnt, mdl_br);
        chk("perf_mis_cnt", perf_mis_cnt, mdl_mis);
`else
        chk("perf_br_cnt", perf_br_cnt, 0);
        chk("perf_mis_cnt", perf_mis_cnt, 0);
`endif
    endtask

    task automatic step(input logic v, input logic [5:0] b, input logic j,
                        input logic [XLEN-1:0] a, input logic [XLEN-1:0] bb,
                        input logic [XLEN-1:0] p, input logic [XLEN-1:0] t,
                        input logic pt, input logic [XLEN-1:0] ptg, input logic [2:0] ps);
        in_valid = v; b_check = b; jump = j; rs1_data = a; rs2_data = bb;
        pc = p; target = t; pred_taken = pt; pred_target = ptg; pc_sel = ps;
        tick();
    endtask

    task automatic idle();
        in_valid = 1'b0;
        tick();
    endtask

    initial begin
        rst = 1'b1; in_valid = 1'b0; b_check = '0; jump = 1'b0;
        rs1_data = '0; rs2_data = '0; pc = '0; target = '0;
        pred_taken = 1'b0; pred_target = '0; pc_sel = '0; flush = 1'b0;
        out_ready = 1'b1;
        @(posedge clk); #1;
        tick(); tick();
        rst = 1'b0;
        chk("rst_out_valid", out_valid, 0);
        chk("rst_out_taken", out_taken, 0);
        chk("rst_out_redirect", out_redirect, 0);
        chk("rst_out_next_pc", out_next_pc, 0);
        chk("rst_pc_sel_out", pc_sel_out, 0);
        chk("rst_br_cnt", perf_br_cnt, 0);
        chk("rst_mis_cnt", perf_mis_cnt, 0);

        // beq taken, predicted not taken -> redirect
        step(1, 6'b100000, 0, 64'h5, 64'h5, 64'h800, 64'h1000, 0, 64'h0, 3'b001);
        chk("beq_taken", out_taken, 1);
        chk("beq_redirect", out_redirect, 1);
        chk("beq_npc", out_next_pc, 64'h1000);
        chk("beq_psel", pc_sel_out, 3'b010);
        // blt -1 < 1 taken, then bltu same operands not taken (back-to-back)
        step(1, 6'b001000, 0, '1, 64'h1, 64'h900, 64'h2000, 1, 64'h2000, 3'b011);
        chk("blt_taken", out_taken, 1);
        step(1, 6'b000010, 0, '1, 64'h1, 64'h900, 64'h2000, 0, 64'h2000, 3'b011);
        chk("bltu_taken", out_taken, 0);
        chk("bltu_npc", out_next_pc, 64'h904);
        // bge most-negative vs most-positive: not taken, no redirect
        step(1, 6'b000100, 0, 64'h8000_0000_0000_0000, 64'h7FFF_FFFF_FFFF_FFFF,
             64'hA00, 64'h3000, 0, 64'h3000, 3'b101);
        chk("bge_taken", out_taken, 0);
        chk("bge_redirect", out_redirect, 0);
        chk("bge_psel", pc_sel_out, 3'b101);
        // b_check=0, no jump: not taken, pred_target irrelevant
        step(1, 6'b000000, 0, 64'h1, 64'h1, 64'hB00, 64'h4000, 0, 64'hDEAD, 3'b100);
        chk("none_redirect", out_redirect, 0);
        // multi-bit select (beq|bltu) with unequal, rs1<rs2 unsigned -> taken
        step(1, 6'b100010, 0, 64'h3, 64'h9, 64'hC00, 64'h5000, 1, 64'h5000, 3'b000);
        chk("multi_taken", out_taken, 1);
        idle();

        // backpressure: accept then hold for 3 cycles
        out_ready = 1'b0;
        step(1, 6'b010000, 0, 64'h1, 64'h2, 64'h100, 64'h7000, 1, 64'h7004, 3'b001);
        for (int i = 0; i < 3; i++) begin
            step(1, 6'b100000, 0, 64'h4, 64'h4, 64'h200, 64'h8000, 0, 64'h0, 3'b110);
            chk("bp_in_ready", in_ready, 0);
            chk("bp_npc_stable", out_next_pc, 64'h7000);
        end
        out_ready = 1'b1;
        step(1, 6'b100000, 0, 64'h4, 64'h4, 64'h200, 64'h8000, 0, 64'h0, 3'b110);
        chk("bp_b2b_npc", out_next_pc, 64'h8000);

        // flush while holding an entry and offering a new one
        out_ready = 1'b0;
        step(1, 6'b000001, 0, 64'h9, 64'h3, 64'h300, 64'h9000, 1, 64'h9000, 3'b010);
        flush = 1'b1; out_ready = 1'b1;
        step(1, 6'b100000, 0, 64'h1, 64'h1, 64'h400, 64'hA000, 1, 64'hA000, 3'b001);
        chk("flush_valid", out_valid, 0);
        flush = 1'b0;
        idle();

        // reset in the middle of a held entry
        out_ready = 1'b0;
        step(1, 6'b100000, 0, 64'h1, 64'h1, 64'h500, 64'hB000, 0, 64'h0, 3'b001);
        rst = 1'b1; in_valid = 1'b0;
        tick();
        rst = 1'b0;
        chk("midrst_valid", out_valid, 0);
        out_ready = 1'b1;

        // jump at top of address space, correctly predicted; then bne wrap
        step(1, 6'b000000, 1, 64'h0, 64'h0, 64'hFFFF_FFFF_FFFF_FFFC, 64'h2000, 1, 64'h2000, 3'b001);
        chk("jump_redirect", out_redirect, 0);
        step(1, 6'b010000, 0, 64'h7, 64'h7, 64'hFFFF_FFFF_FFFF_FFFC, 64'h2000, 1, 64'h2000, 3'b001);
        chk("wrap_taken", out_taken, 0);
        chk("wrap_npc", out_next_pc, 64'h0);
        chk("wrap_redirect", out_redirect, 1);
        idle();
`ifdef BRU_PERF_CNT_EN
        chk("plan_br_cnt", perf_br_cnt, 2);
        chk("plan_mis_cnt", perf_mis_cnt, 1);
`endif

        // random burst, long enough to saturate the narrow counters
        for (int i = 0; i < 24; i++) begin
            out_ready = ($urandom_range(0, 3) != 0);
            step($urandom_range(0, 3) != 0, 6'($urandom), ($urandom_range(0, 3) == 0),
                 {$urandom, $urandom}, (i % 4 == 0) ? rs1_data : {$urandom, $urandom},
                 {$urandom, $urandom}, {32'h0, $urandom}, 1'($urandom),
                 ($urandom_range(0, 1) == 0) ? target : {32'h0, $urandom}, 3'($urandom));
        end
        out_ready = 1'b1;
        idle(); idle();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
